fetch_stage: RTL and testbench

//   Instruction Fetch (F) stage; feeds instr_D/pc_D to Decode, where the control unit consumes them.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/fetch_queue.sv | 94 +++++++++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: reset PC default, NOP
// encoding, fetch FSM states, prefetch queue entry layout and PC helpers.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_INCR      = 32'h0000_0004;

  // RUN: nothing in flight; WAIT: one request in flight;
  // SQUASH: the in-flight response belongs to a redirected-away path.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_WAIT   = 2'b01,
    ST_SQUASH = 2'b10
  } fetch_state_e;

  // One prefetch queue slot: the word and the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pq_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential next fetch address; wraps silently at the top of memory.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH-entry FIFO of {pc, instr}. Clear has priority over
// push/pop; a push into a full queue is accepted when a pop happens in the
// same cycle. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  pq_entry_t                i_push_data,
  input  logic                     i_pop,
  output pq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pq_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_empty = (r_count == {CW{1'b0}});
  assign w_full  = (r_count == CW'(DEPTH));

  // Qualify push/pop against occupancy; full-queue push only with a pop.
  always_comb begin
    w_push_ok = 1'b0;
    w_pop_ok  = 1'b0;
    if (i_pop && !w_empty) begin
      w_pop_ok = 1'b1;
    end else begin
      w_pop_ok = 1'b0;
    end
    if (i_push && (!w_full || w_pop_ok)) begin
      w_push_ok = 1'b1;
    end else begin
      w_push_ok = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_clear) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so an empty head reads as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction Fetch stage: PC register, single-outstanding request FSM with
// squash tracking for redirects, and a prefetch queue feeding Decode.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cyc.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          PQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_D,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        valid_D,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cyc,
`endif
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(PQ_DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;

  pq_entry_t     w_head;
  pq_entry_t     w_push_data;
  logic [CW-1:0] w_q_count;
  logic          w_q_empty;
  logic          w_q_full;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [CW-1:0] w_occ_after;

  assign w_push_data.pc    = r_pc - PC_INCR;
  assign w_push_data.instr = imem_rdata;

  fetch_queue #(
    .DEPTH (PQ_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_q_count),
    .o_empty     (w_q_empty),
    .o_full      (w_q_full)
  );

  // Push/pop qualification and issue decision; a redirect suppresses all three.
  always_comb begin
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_issue     = 1'b0;
    w_occ_after = {CW{1'b0}};
    if (!w_q_empty && !stall_D && !redirect_valid) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    if ((r_state == ST_WAIT) && imem_rvalid && !redirect_valid) begin
      w_push = 1'b1;
    end else begin
      w_push = 1'b0;
    end
    w_occ_after = w_q_count + CW'(w_push) - CW'(w_pop);
    // Occupancy must leave room for the response of the request issued now.
    if (rst_n && !redirect_valid &&
        ((r_state == ST_RUN) || ((r_state == ST_WAIT) && imem_rvalid)) &&
        (w_occ_after < CW'(PQ_DEPTH))) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
  end

  // Next-state and next-PC logic for the fetch FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = word_align(redirect_pc);
      case (r_state)
        ST_RUN:    w_state_nxt = ST_RUN;
        ST_WAIT:   w_state_nxt = imem_rvalid ? ST_RUN : ST_SQUASH;
        // A squashed response landing now retires the only outstanding request.
        ST_SQUASH: w_state_nxt = imem_rvalid ? ST_RUN : ST_SQUASH;
        default:   w_state_nxt = ST_RUN;
      endcase
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_issue) begin
            w_state_nxt = ST_WAIT;
            w_pc_nxt    = pc_next(r_pc);
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid && w_issue) begin
            w_state_nxt = ST_WAIT;
            w_pc_nxt    = pc_next(r_pc);
          end else if (imem_rvalid) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_SQUASH: begin
          if (imem_rvalid) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_SQUASH;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // FSM state and PC registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= word_align(RESET_PC);
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  assign valid_D   = !w_q_empty;
  assign instr_D   = w_q_empty ? NOP_INSTR : w_head.instr;
  assign pc_D      = w_q_empty ? 32'h0000_0000 : w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall_cyc;

  // Words accepted into the queue and cycles Decode held a valid word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched   <= 32'h0000_0000;
      r_perf_stall_cyc <= 32'h0000_0000;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'h0000_0001;
      end
      if (!w_q_empty && stall_D) begin
        r_perf_stall_cyc <= r_perf_stall_cyc + 32'h0000_0001;
      end
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The reference is a stream model: the
// words reaching Decode must be consecutive addresses starting at the last
// reset/redirect target, each carrying addr ^ KEY from the memory model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_D;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid_D;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cyc;
`endif

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_D        (stall_D),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .valid_D        (valid_D),
    .instr_D        (instr_D),
    .pc_D           (pc_D),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_stall_cyc (perf_stall_cyc),
`endif
    .pc_out         (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
    int          era;
  } req_t;

  req_t        mem_q[$];
  int          cyc, epoch, era, lat_min, lat_max;
  int          n_vec, n_err, delivered;
  logic [31:0] exp_pc, exp_req, exp_fetched, exp_stall;
  bit          prev_rst;
  bit          s_valid, s_req, s_resp, s_redir;
  logic [31:0] s_addr, s_pcD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, let the memory respond, check, update model.
  // redir_mode: 0 none, 1 redirect, 2 redirect only if a response lands now.
  task automatic step(input bit stall, input bit rst, input int redir_mode, input logic [31:0] tgt);
    bit   resp;
    bit   redir;
    int   busy;
    req_t ent;
    @(negedge clk);
    stall_D     = stall;
    rst_n       = !rst;
    resp        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid = resp;
    imem_rdata  = resp ? (mem_q[0].addr ^ KEY) : 32'hDEAD_BEEF;
    redir       = (redir_mode == 1) || ((redir_mode == 2) && resp);
    redirect_valid = redir;
    redirect_pc    = tgt;
    #1;
    if (rst) begin
      chk("req_in_reset", {31'd0, imem_req}, 32'd0);
      if (prev_rst) begin
        chk("rst_valid_D", {31'd0, valid_D}, 32'd0);
        chk("rst_instr_D", instr_D, 32'd0);
        chk("rst_pc_D", pc_D, 32'd0);
        chk("rst_pc_out", pc_out, RST_PC);
      end
    end else begin
      chk("pc_out", pc_out, exp_req);
      if (valid_D) begin
        chk("pc_D", pc_D, exp_pc);
        chk("instr_D", instr_D, exp_pc ^ KEY);
      end else begin
        chk("pc_D_idle", pc_D, 32'd0);
        chk("instr_D_idle", instr_D, 32'd0);
      end
      if (redir) chk("req_on_redirect", {31'd0, imem_req}, 32'd0);
      if (imem_req) begin
        chk("imem_addr", imem_addr, exp_req);
        busy = 0;
        foreach (mem_q[i]) if (mem_q[i].era == era) busy++;
        if (resp && mem_q[0].era == era) busy--;
        chk("one_outstanding", busy, 32'd0);
      end
      chk("occupancy_bound", {31'd0, ((exp_req - exp_pc) <= 32'(4 * DEPTH))}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, exp_fetched);
      chk("perf_stall_cyc", perf_stall_cyc, exp_stall);
`endif
    end
    s_valid = valid_D; s_req = imem_req; s_addr = imem_addr;
    s_pcD = pc_D; s_resp = resp; s_redir = redir;
    @(posedge clk);
    if (resp) begin
      if (!rst && !redir && mem_q[0].epoch == epoch) exp_fetched++;
      void'(mem_q.pop_front());
    end
    if (!rst && s_valid && stall) exp_stall++;
    if (s_req) begin
      ent.addr = s_addr; ent.due = cyc + $urandom_range(lat_max, lat_min);
      ent.epoch = epoch; ent.era = era;
      mem_q.push_back(ent);
    end
    if (rst) begin
      exp_pc = RST_PC; exp_req = RST_PC; epoch++; era++;
      exp_fetched = 32'd0; exp_stall = 32'd0;
    end else if (redir) begin
      exp_pc = tgt & 32'hFFFF_FFFC; exp_req = tgt & 32'hFFFF_FFFC; epoch++;
    end else begin
      if (s_valid && !stall) begin exp_pc += 32'd4; delivered++; end
      if (s_req) exp_req += 32'd4;
    end
    prev_rst = rst;
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 0, 32'd0);
    step(1'b0, 1'b1, 0, 32'd0);
  endtask

  initial begin
    bit found;
    int d0;
    rst_n = 1'b0; stall_D = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    cyc = 0; epoch = 0; era = 0; n_vec = 0; n_err = 0; delivered = 0;
    exp_pc = RST_PC; exp_req = RST_PC; exp_fetched = 32'd0; exp_stall = 32'd0;
    prev_rst = 1'b0;
    lat_min = 1; lat_max = 1;

    // 1: back-to-back fetch with 1-cycle memory
    do_reset();
    d0 = delivered;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 0, 32'd0);
      chk("t1_req", {31'd0, s_req}, 32'd1);
      chk("t1_addr", s_addr, 32'(4 * i));
      chk("t1_valid", {31'd0, s_valid}, (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("t1_delivered", delivered - d0, 32'd10);

    // 2: Decode stall fills the queue, then drains in order
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 32'd0);
    chk("t2_req_held", {31'd0, s_req}, 32'd0);
    chk("t2_head_valid", {31'd0, s_valid}, 32'd1);
    chk("t2_head_pc", s_pcD, 32'd0);
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t2_pop0", s_pcD, 32'd0);
    chk("t2_resume_req", {31'd0, s_req}, 32'd1);
    chk("t2_resume_addr", s_addr, 32'd8);
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t2_pop4", s_pcD, 32'd4);

    // 3: redirect while the request to 0x8 is in flight (3-cycle memory)
    lat_min = 3; lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b0, 1'b0, 0, 32'd0);
      if (s_req && s_addr == 32'd8) found = 1'b1;
    end
    chk("t3_reach8", {31'd0, found}, 32'd1);
    step(1'b0, 1'b0, 0, 32'd0);
    step(1'b0, 1'b0, 1, 32'h0000_0100);
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t3_q_empty", {31'd0, s_valid}, 32'd0);
    chk("t3_squash_rsp", {31'd0, s_resp}, 32'd1);
    chk("t3_no_req_squash", {31'd0, s_req}, 32'd0);
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t3_req_target", {31'd0, s_req}, 32'd1);
    chk("t3_addr_target", s_addr, 32'h0000_0100);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1'b0, 1'b0, 0, 32'd0);
      if (s_valid) begin found = 1'b1; chk("t3_first_pc", s_pcD, 32'h0000_0100); end
    end
    chk("t3_valid_seen", {31'd0, found}, 32'd1);

    // 4: redirect coincident with a response while Decode stalls
    lat_min = 2; lat_max = 2;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1'b1, 1'b0, 2, 32'h0000_0203);
      found = s_redir;
    end
    chk("t4_redirect_hit", {31'd0, found}, 32'd1);
    step(1'b1, 1'b0, 0, 32'd0);
    chk("t4_dropped", {31'd0, s_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 32'd0);
    chk("t4_head_target", s_pcD, 32'h0000_0200);
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t4_pop_target", s_pcD, 32'h0000_0200);

    // 5: reset while waiting; the late response must be ignored
    do_reset();
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t5_req", {31'd0, s_req}, 32'd1);
    step(1'b0, 1'b1, 0, 32'd0);
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t5_late_rsp", {31'd0, s_resp}, 32'd1);
    chk("t5_restart_req", {31'd0, s_req}, 32'd1);
    chk("t5_restart_addr", s_addr, RST_PC);
    step(1'b0, 1'b0, 0, 32'd0);
    chk("t5_late_ignored", {31'd0, s_valid}, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1'b0, 1'b0, 0, 32'd0);
      if (s_valid) begin found = 1'b1; chk("t5_first_pc", s_pcD, RST_PC); end
    end
    chk("t5_valid_seen", {31'd0, found}, 32'd1);

    // PC wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 1, 32'hFFFF_FFFB);
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 0, 32'd0);
      if (s_valid && s_pcD == 32'd0) found = 1'b1;
    end
    chk("wrap_to_zero", {31'd0, found}, 32'd1);

    // Randomized traffic: stalls, redirects, variable latency, resets
    lat_min = 1; lat_max = 4;
    do_reset();
    d0 = delivered;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] tgt;
      r   = $urandom_range(99, 0);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      if (r < 1) begin
        step(1'b0, 1'b1, 0, 32'd0);
        for (int k = 0; k < 8 && mem_q.size() > 0; k++) step(1'b0, 1'b1, 0, 32'd0);
      end else begin
        step(($urandom_range(9, 0) < 3), 1'b0, (r < 6) ? 1 : 0, tgt);
      end
    end
    chk("random_progress", {31'd0, ((delivered - d0) > 30)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
